fulladd_serial: RTL

Parametrised, multi-cycle ripple adder: adds two W-bit operands plus carry-in by stepping a D-bit ripple-carry slice across the operands, one digit per clock, with a registered carry between digits. Operands and results use a valid/ready handshake on each side, so the block sits between a producer and a consumer in the datapath. It trades latency for area when W is wide: one D-bit slice serves the whole operand width.

---
 rtl/fulladd_serial_if.sv | 39 +++
 rtl/fulladd_serial.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/fulladd_serial_if.sv
// Valid/ready operand and result bundle for fulladd_serial.
// The sub signal exists only when FULLADD_SERIAL_SUB_EN is defined.
interface fulladd_serial_if #(
  parameter int unsigned W = 8
);
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
`ifdef FULLADD_SERIAL_SUB_EN
  logic         sub;
`endif
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] s;
  logic         cout;
  logic         ovf;

`ifdef FULLADD_SERIAL_SUB_EN
  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`else
  modport master (
    output in_valid, a, b, cin, out_ready,
    input  in_ready, out_valid, s, cout, ovf
  );
  modport slave (
    input  in_valid, a, b, cin, out_ready,
    output in_ready, out_valid, s, cout, ovf
  );
`endif
endinterface

// File: rtl/fulladd_serial.sv
// Digit-serial ripple adder: one D-bit slice stepped over W-bit operands, one digit per clock.
// Optional subtract mode enabled by defining FULLADD_SERIAL_SUB_EN.
module fulladd_serial #(
  parameter int unsigned W = 8,
  parameter int unsigned D = 2
) (
  input  logic          clk,
  input  logic          rst,
  fulladd_serial_if.slave bus
);
  localparam int unsigned N  = (D >= 1) ? (W / D) : 1;
  localparam int unsigned CW = (N > 1) ? $clog2(N) : 1;

  if ((W < 1) || (D < 1) || (D > W) || ((W % D) != 0)) begin : g_bad_params
    $error("fulladd_serial: illegal W/D combination");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t        state_q, state_n;
  logic [CW-1:0] cnt_q, cnt_n;
  logic          carry_q, carry_n;
  logic [W-1:0]  work_q, work_n;
  logic [W-1:0]  a_q, a_n;
  logic [W-1:0]  beff_q, beff_n;
  logic [W-1:0]  s_q, s_n;
  logic          cout_q, cout_n;
  logic          ovf_q, ovf_n;
  logic          in_ready_q, in_ready_n;
  logic          out_valid_q, out_valid_n;

  logic [D-1:0]  a_dig;
  logic [D-1:0]  b_dig;
  logic [D:0]    dres;
  logic          sub_eff;

`ifdef FULLADD_SERIAL_SUB_EN
  assign sub_eff = bus.sub;
`else
  assign sub_eff = 1'b0;
`endif

  // Next-state, datapath step and registered-output decode
  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    carry_n  = carry_q;
    work_n   = work_q;
    a_n      = a_q;
    beff_n   = beff_q;
    s_n      = s_q;
    cout_n   = cout_q;
    ovf_n    = ovf_q;
    a_dig    = '0;
    b_dig    = '0;
    dres     = '0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          a_n     = bus.a;
          beff_n  = bus.b ^ {W{sub_eff}};
          carry_n = bus.cin ^ sub_eff;
          cnt_n   = '0;
          state_n = RUN;
        end
      end
      RUN: begin
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            a_dig = a_q[k*D +: D];
            b_dig = beff_q[k*D +: D];
          end
        end
        dres = {1'b0, a_dig} + {1'b0, b_dig} + (D+1)'(carry_q);
        for (int k = 0; k < N; k++) begin
          if (cnt_q == CW'(k)) begin
            work_n[k*D +: D] = dres[D-1:0];
          end
        end
        carry_n = dres[D];
        cnt_n   = cnt_q + CW'(1);
        // Last digit: publish the result and freeze it until the next completion
        if (cnt_q == CW'(N - 1)) begin
          s_n     = work_n;
          cout_n  = dres[D];
          ovf_n   = (a_q[W-1] == beff_q[W-1]) & (work_n[W-1] != a_q[W-1]);
          state_n = DONE;
        end
      end
      DONE: begin
        if (bus.out_ready) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase

    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  // State and datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      work_q      <= '0;
      a_q         <= '0;
      beff_q      <= '0;
      s_q         <= '0;
      cout_q      <= 1'b0;
      ovf_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_n;
      cnt_q       <= cnt_n;
      carry_q     <= carry_n;
      work_q      <= work_n;
      a_q         <= a_n;
      beff_q      <= beff_n;
      s_q         <= s_n;
      cout_q      <= cout_n;
      ovf_q       <= ovf_n;
      in_ready_q  <= in_ready_n;
      out_valid_q <= out_valid_n;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.s         = s_q;
  assign bus.cout      = cout_q;
  assign bus.ovf       = ovf_q;

endmodule
